// File: rtl/sram_emu_sliced.sv
// Level-encoded SRAM model: hysteresis slicers on every input line feed a word array
// that clears itself after reset, with read-first/write-first ordering and a RD_LATENCY-deep read pipe.

module sram_emu_sliced #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ANA_WIDTH  = 8,
  parameter int FULL_SCALE = 255,
  parameter int THRESH_HI  = 170,
  parameter int THRESH_LO  = 85,
  parameter int READ_MODE  = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic                                 clk_a,
  input  logic                                 rst_n_a,
  input  logic [ANA_WIDTH-1:0]                 req_a,
  input  logic [ANA_WIDTH-1:0]                 we_a,
  input  logic [ADDR_WIDTH-1:0][ANA_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0] dout_a,
  output logic [ANA_WIDTH-1:0]                 rvalid_a,
  output logic [ANA_WIDTH-1:0]                 ready_a
);
  localparam int DEPTH     = 2**ADDR_WIDTH;
  localparam int NUM_LINES = 2 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ANA_WIDTH-1:0] FS    = ANA_WIDTH'(FULL_SCALE);
  localparam logic [ANA_WIDTH-1:0] TH_HI = ANA_WIDTH'(THRESH_HI);
  localparam logic [ANA_WIDTH-1:0] TH_LO = ANA_WIDTH'(THRESH_LO);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  // Line order, LSB first: req, we, addr[], din[]
  logic [NUM_LINES-1:0][ANA_WIDTH-1:0] lvl;
  logic [NUM_LINES-1:0]                sl;

  assign lvl = {din_a, addr_a, we_a, req_a};

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_slc
    // Levels between the thresholds keep the previous decision
    always_ff @(posedge clk_a or negedge rst_n_a) begin
      if (!rst_n_a)              sl[g] <= 1'b0;
      else if (lvl[g] >= TH_HI)  sl[g] <= 1'b1;
      else if (lvl[g] <= TH_LO)  sl[g] <= 1'b0;
    end
  end

  logic                  s_req, s_we;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_din;

  assign s_req  = sl[0];
  assign s_we   = sl[1];
  assign s_addr = sl[2 +: ADDR_WIDTH];
  assign s_din  = sl[2+ADDR_WIDTH +: DATA_WIDTH];

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  acc;

  always_ff @(posedge clk_a or negedge rst_n_a) begin
    if (!rst_n_a) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= ST_IDLE;
    end
  end

  // Requests seen during INIT are simply ignored
  assign acc = (state == ST_IDLE) && s_req;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clk_a) begin
    if (state == ST_INIT)    mem[cnt]    <= '0;
    else if (acc && s_we)    mem[s_addr] <= s_din;
  end

  assign rd_word = (READ_MODE != 0 && s_we) ? s_din : mem[s_addr];

  // Data stages only load on a valid beat, so the last stage holds the previous word
  logic [RD_LATENCY:1]                 vld_pipe;
  logic [RD_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk_a or negedge rst_n_a) begin
    if (!rst_n_a) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= acc;
      if (acc) dat_pipe[1] <= rd_word;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_dout
    assign dout_a[g] = dat_pipe[RD_LATENCY][g] ? FS : '0;
  end

  assign rvalid_a = vld_pipe[RD_LATENCY] ? FS : '0;
  assign ready_a  = (state == ST_IDLE)   ? FS : '0;

endmodule
